pll_lock_supervisor: RTL and testbench
======================================

// Module: pll_lock_supervisor
// PURPOSE
//  Reset and lock sequencer that sits on the other end of the clock PLL: it drives the PLL reset input and consumes the PLL locked output.
//  Pulses the PLL reset, waits for lock, and holds the system reset until lock has been stable for a qualification window.
//  On loss of lock it re-asserts system reset and re-arms the PLL. After repeated lock timeouts it declares a sticky fault.
//  Runs on the free-running 50 MHz refclk, never on a PLL output.
// PARAMETERS
//  PLL_RST_CYCLES  16     cycles pll_rst is held high per PLL reset pulse (>=1)
//  LOCK_TIMEOUT    50000  max cycles in WAIT_LOCK before a retry (1 ms @ 50 MHz)
//  HOLD_CYCLES     5000   cycles of continuous synced lock required before releasing sys_rst (>=1)
//  MAX_RETRIES     3      lock timeouts tolerated before FAULT (1..15)
//  SYNC_STAGES     2      synchronizer depth on pll_locked (>=2)
// PORTS
//  refclk      in   1  single clock; all logic sits on this domain
//  rst         in   1  synchronous, active-high reset
//  pll_locked  in   1  PLL locked; asynchronous to refclk
//  pll_rst     out  1  reset to PLL; high = PLL held in reset
//  sys_rst     out  1  reset to PLL-clocked logic; high = hold in reset
//  lock_lost   out  1  one-cycle pulse when lock drops while in RUN
//  retry_cnt   out  4  lock timeouts since the last RUN entry or rst
//  fault       out  1  sticky; set on entering FAULT, cleared only by rst
// BEHAVIOUR
//  - Reset values: state=PLLRST, pll_rst=1, sys_rst=1, lock_lost=0, retry_cnt=0, fault=0, all counters 0.
//  - All outputs are registered.
//  - lk = pll_locked after SYNC_STAGES flops. The FSM acts on lk only.
//  - PLLRST: pll_rst=1, sys_rst=1, cnt++.
//    At cnt==PLL_RST_CYCLES-1: go to WAIT_LOCK, cnt=0.
//    lk is ignored in this state.
//  - WAIT_LOCK: pll_rst=0, sys_rst=1.
//    lk=1: go to HOLD, cnt=0.
//    Else at cnt==LOCK_TIMEOUT-1: retry_cnt++.
//      If the new value == MAX_RETRIES, go to FAULT.
//      Otherwise go to PLLRST.
//    If lk=1 and the timeout occur in the same cycle, lk=1 wins.
//  - HOLD: pll_rst=0, sys_rst=1.
//    lk=0: back to WAIT_LOCK; the timeout counter restarts at 0 and retry_cnt is unchanged.
//    Else at cnt==HOLD_CYCLES-1: go to RUN.
//  - RUN: sys_rst=0, retry_cnt cleared on entry.
//    lk=0: lock_lost=1 for one cycle, sys_rst=1 at the same edge, go to PLLRST. retry_cnt is not incremented.
//  - FAULT: pll_rst=1, sys_rst=1, fault=1. Terminal until rst.
//  - Latency: if pll_locked rises while in WAIT_LOCK and stays high, sys_rst falls exactly SYNC_STAGES+1+HOLD_CYCLES cycles later.
//    When pll_locked falls in RUN, sys_rst rises SYNC_STAGES+1 cycles later.
//  - A single shared counter is sized $clog2(max(PLL_RST_CYCLES, LOCK_TIMEOUT, HOLD_CYCLES)). It is reset on every state change.
//  - retry_cnt saturates; it never wraps.
//  - rst asserted mid-operation (any state, including FAULT): reset values at the next edge. The synchronizer flops also clear.
// STRUCTURE
//  - Package pll_sup_pkg holds:
//    - state enum {PLLRST, WAIT_LOCK, HOLD, RUN, FAULT};
//    - default timing constants;
//    - helper function cnt_width().
//  - Sub-module sync_bit (SYNC_STAGES-deep flop chain with synchronous clear) for pll_locked.
//  - Top: FSM, shared counter, retry counter, output registers.
// TESTING (params: PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, HOLD_CYCLES=8, MAX_RETRIES=2, SYNC_STAGES=2)
//  1. Release rst, raise pll_locked 10 cycles later -> pll_rst high for exactly 4 cycles; sys_rst falls exactly 11 cycles after pll_locked rises.
//  2. In HOLD, drop pll_locked for 1 cycle at hold count 5 -> FSM returns to WAIT_LOCK, sys_rst stays 1, full 8-cycle hold restarts.
//  3. pll_locked held 0 -> retry_cnt 1 after the first 32-cycle timeout, then a 4-cycle pll_rst pulse. Second timeout -> fault=1, pll_rst=1, sys_rst=1, steady for 100+ cycles.
//  4. In RUN, drop pll_locked -> lock_lost pulses once, sys_rst=1 3 cycles after the drop, 4-cycle pll_rst pulse, retry_cnt stays 0. Relock -> RUN again.
//  5. Assert rst mid-HOLD and again while in FAULT -> next edge: pll_rst=1, sys_rst=1, fault=0, retry_cnt=0, state PLLRST.
//  6. pll_locked already 1 throughout PLLRST -> no early HOLD. sys_rst falls 4+1+8 cycles after rst release.

Source files
------------

// File: rtl/pll_lock_supervisor_pkg.sv
// PLL lock supervisor: shared state encoding, default timing and helpers.
// Default timing assumes a 50 MHz free-running reference clock.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    PLLRST,
    WAIT_LOCK,
    HOLD,
    RUN,
    FAULT
  } state_t;

  localparam int unsigned DEF_PLL_RST_CYCLES = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT   = 50000;
  localparam int unsigned DEF_HOLD_CYCLES    = 5000;
  localparam int unsigned DEF_MAX_RETRIES    = 3;
  localparam int unsigned DEF_SYNC_STAGES    = 2;
  localparam int unsigned RETRY_W            = 4;

  // Width of the one counter shared by all timed states.
  function automatic int unsigned cnt_width(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// PLL-side and system-side signals of the lock supervisor.
// The master modport is the supervisor; the slave is PLL plus system.
interface pll_lock_supervisor_if;
  import pll_sup_pkg::*;

  logic               pll_locked;
  logic               pll_rst;
  logic               sys_rst;
  logic               lock_lost;
  logic [RETRY_W-1:0] retry_cnt;
  logic               fault;

  modport master (
    input  pll_locked,
    output pll_rst,
    output sys_rst,
    output lock_lost,
    output retry_cnt,
    output fault
  );

  modport slave (
    output pll_locked,
    input  pll_rst,
    input  sys_rst,
    input  lock_lost,
    input  retry_cnt,
    input  fault
  );

endinterface

// File: rtl/pll_lock_supervisor_sync_bit.sv
// Multi-flop synchronizer with synchronous clear for one async bit.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, qualifies lock, and gates the system reset.
// Outputs are registered from the next-state decode.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES,
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES
) (
  input logic                   refclk,
  input logic                   rst,
  pll_lock_supervisor_if.master bus
);

  localparam int unsigned CW =
    cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, HOLD_CYCLES);

  localparam logic [CW-1:0] PR_END = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] LT_END = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] HD_END = CW'(HOLD_CYCLES - 1);
  localparam logic [RETRY_W-1:0] R_MAX = RETRY_W'(MAX_RETRIES);
  localparam logic [RETRY_W-1:0] R_SAT = '1;

  logic               lk;
  state_t             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [RETRY_W-1:0] retry, retry_n;
  logic               lost_n;
  logic               pll_rst_q, sys_rst_q, lost_q, fault_q;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (refclk),
    .rst (rst),
    .d   (bus.pll_locked),
    .q   (lk)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    retry_n = retry;
    lost_n  = 1'b0;
    unique case (state)
      PLLRST: begin
        if (cnt == PR_END) state_n = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lk) begin
          state_n = HOLD;
        end else if (cnt == LT_END) begin
          if (retry != R_SAT) retry_n = retry + 1'b1;
          state_n = (retry_n == R_MAX) ? FAULT : PLLRST;
        end
      end
      HOLD: begin
        if (!lk) begin
          state_n = WAIT_LOCK;
        end else if (cnt == HD_END) begin
          state_n = RUN;
          retry_n = '0;
        end
      end
      RUN: begin
        cnt_n = cnt;
        if (!lk) begin
          state_n = PLLRST;
          lost_n  = 1'b1;
        end
      end
      FAULT: begin
        cnt_n = cnt;
      end
      default: begin
        state_n = PLLRST;
      end
    endcase
    if (state_n != state) cnt_n = '0;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= PLLRST;
      cnt       <= '0;
      retry     <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      lost_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      retry     <= retry_n;
      pll_rst_q <= (state_n == PLLRST) || (state_n == FAULT);
      sys_rst_q <= (state_n != RUN);
      lost_q    <= lost_n;
      fault_q   <= (state_n == FAULT);
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_rst   = sys_rst_q;
  assign bus.lock_lost = lost_q;
  assign bus.retry_cnt = retry;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short timing parameters.
module tb_pll_lock_supervisor;

  logic refclk = 1'b0;
  logic rst    = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  pll_lock_supervisor_if bus ();

  pll_lock_supervisor #(
    .PLL_RST_CYCLES (4),
    .LOCK_TIMEOUT   (32),
    .HOLD_CYCLES    (8),
    .MAX_RETRIES    (2),
    .SYNC_STAGES    (2)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.pll_locked = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_pll_rst", 8'(bus.pll_rst), 8'd1);
    chk("rst_sys_rst", 8'(bus.sys_rst), 8'd1);
    chk("rst_lost", 8'(bus.lock_lost), 8'd0);
    chk("rst_retry", 8'(bus.retry_cnt), 8'd0);
    chk("rst_fault", 8'(bus.fault), 8'd0);

    // 1: power-up, lock 10 cycles after release
    rst = 1'b0;
    repeat (3) tick();
    chk("t1_pll_rst_hi", 8'(bus.pll_rst), 8'd1);
    tick();
    chk("t1_pll_rst_lo", 8'(bus.pll_rst), 8'd0);
    repeat (6) tick();
    bus.pll_locked = 1'b1;
    repeat (10) tick();
    chk("t1_sys_rst_10", 8'(bus.sys_rst), 8'd1);
    tick();
    chk("t1_sys_rst_11", 8'(bus.sys_rst), 8'd0);
    chk("t1_retry", 8'(bus.retry_cnt), 8'd0);

    // 4: lock loss in RUN, then relock
    bus.pll_locked = 1'b0;
    repeat (2) tick();
    chk("t4_sys_rst_2", 8'(bus.sys_rst), 8'd0);
    chk("t4_lost_2", 8'(bus.lock_lost), 8'd0);
    tick();
    chk("t4_sys_rst_3", 8'(bus.sys_rst), 8'd1);
    chk("t4_lost_3", 8'(bus.lock_lost), 8'd1);
    chk("t4_pll_rst_3", 8'(bus.pll_rst), 8'd1);
    tick();
    chk("t4_lost_4", 8'(bus.lock_lost), 8'd0);
    repeat (2) tick();
    chk("t4_pll_rst_6", 8'(bus.pll_rst), 8'd1);
    tick();
    chk("t4_pll_rst_7", 8'(bus.pll_rst), 8'd0);
    chk("t4_retry", 8'(bus.retry_cnt), 8'd0);
    bus.pll_locked = 1'b1;
    repeat (10) tick();
    chk("t4_relock_10", 8'(bus.sys_rst), 8'd1);
    tick();
    chk("t4_relock_11", 8'(bus.sys_rst), 8'd0);

    // 2: one-cycle lock glitch at hold count 5 restarts the hold
    rst = 1'b1;
    bus.pll_locked = 1'b0;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    bus.pll_locked = 1'b1;
    repeat (8) tick();
    bus.pll_locked = 1'b0;
    tick();
    bus.pll_locked = 1'b1;
    tick();
    chk("t2_sys_rst_10", 8'(bus.sys_rst), 8'd1);
    tick();
    chk("t2_sys_rst_11", 8'(bus.sys_rst), 8'd1);
    repeat (8) tick();
    chk("t2_sys_rst_19", 8'(bus.sys_rst), 8'd1);
    tick();
    chk("t2_sys_rst_20", 8'(bus.sys_rst), 8'd0);

    // 5a + 6: rst mid-HOLD, lock already high throughout PLLRST
    rst = 1'b1;
    bus.pll_locked = 1'b0;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    bus.pll_locked = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("t5_hold_pll_rst", 8'(bus.pll_rst), 8'd1);
    chk("t5_hold_sys_rst", 8'(bus.sys_rst), 8'd1);
    chk("t5_hold_fault", 8'(bus.fault), 8'd0);
    chk("t5_hold_retry", 8'(bus.retry_cnt), 8'd0);
    rst = 1'b0;
    repeat (3) tick();
    chk("t6_pll_rst_3", 8'(bus.pll_rst), 8'd1);
    tick();
    chk("t6_pll_rst_4", 8'(bus.pll_rst), 8'd0);
    repeat (8) tick();
    chk("t6_sys_rst_12", 8'(bus.sys_rst), 8'd1);
    tick();
    chk("t6_sys_rst_13", 8'(bus.sys_rst), 8'd0);

    // 3: no lock at all -> two timeouts -> FAULT
    rst = 1'b1;
    bus.pll_locked = 1'b0;
    tick();
    rst = 1'b0;
    repeat (35) tick();
    chk("t3_retry_35", 8'(bus.retry_cnt), 8'd0);
    chk("t3_pll_rst_35", 8'(bus.pll_rst), 8'd0);
    tick();
    chk("t3_retry_36", 8'(bus.retry_cnt), 8'd1);
    chk("t3_pll_rst_36", 8'(bus.pll_rst), 8'd1);
    repeat (3) tick();
    chk("t3_pll_rst_39", 8'(bus.pll_rst), 8'd1);
    tick();
    chk("t3_pll_rst_40", 8'(bus.pll_rst), 8'd0);
    repeat (31) tick();
    chk("t3_fault_71", 8'(bus.fault), 8'd0);
    chk("t3_retry_71", 8'(bus.retry_cnt), 8'd1);
    tick();
    chk("t3_fault_72", 8'(bus.fault), 8'd1);
    chk("t3_retry_72", 8'(bus.retry_cnt), 8'd2);
    chk("t3_pll_rst_72", 8'(bus.pll_rst), 8'd1);
    chk("t3_sys_rst_72", 8'(bus.sys_rst), 8'd1);
    bus.pll_locked = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("t3_fault_steady",
          8'({bus.fault, bus.pll_rst, bus.sys_rst, bus.lock_lost}),
          8'b1110);
    end
    chk("t3_retry_steady", 8'(bus.retry_cnt), 8'd2);

    // 5b: rst while in FAULT
    rst = 1'b1;
    tick();
    chk("t5_flt_fault", 8'(bus.fault), 8'd0);
    chk("t5_flt_retry", 8'(bus.retry_cnt), 8'd0);
    chk("t5_flt_pll_rst", 8'(bus.pll_rst), 8'd1);
    chk("t5_flt_sys_rst", 8'(bus.sys_rst), 8'd1);
    rst = 1'b0;
    bus.pll_locked = 1'b0;
    repeat (3) tick();
    chk("t5_flt_pll_rst_3", 8'(bus.pll_rst), 8'd1);
    tick();
    chk("t5_flt_pll_rst_4", 8'(bus.pll_rst), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
